// File: rtl/vc_switch_allocator_rr.sv
// ---------------------------------------------------------------------------
// vc_switch_allocator_rr
//
// Registered two-stage separable round-robin switch allocator for a NoC
// router. Each cycle every input port first picks one eligible virtual
// channel (VC stage, round-robin from vc_ptr), then every output port picks
// one of the inputs whose VC winner targets it (input stage, round-robin
// from in_ptr). A (input, VC) head is only eligible when the downstream
// buffer for (requested output, VC) still has credit.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req            request valid per (input, VC), index in*VC_NUM+vc
//   req_port       requested output port per (input, VC), PORT_W bits each
//   flit_in        head flit per (input, VC), FLIT_SIZE bits each
//   credit_in      one-cycle credit return per (output, VC)
//   grant          combinational pop per (input, VC); also upstream credit
//   flit_out       registered flit per output port
//   flit_valid_out registered valid per output port
//   vc_out         registered VC tag per output port
//   credit_err     sticky credit counter overflow/underflow flag
// ---------------------------------------------------------------------------
module vc_switch_allocator_rr #(
   parameter int PORT_CNT     = 5,
   parameter int VC_NUM       = 4,
   parameter int FLIT_SIZE    = 32,
   parameter int CREDIT_DEPTH = 4,
   parameter int PORT_W       = 3,
   localparam int VC_W        = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [PORT_CNT*VC_NUM-1:0]            req,
   input  logic [PORT_CNT*VC_NUM*PORT_W-1:0]     req_port,
   input  logic [PORT_CNT*VC_NUM*FLIT_SIZE-1:0]  flit_in,
   input  logic [PORT_CNT*VC_NUM-1:0]            credit_in,
   output logic [PORT_CNT*VC_NUM-1:0]            grant,
   output logic [PORT_CNT*FLIT_SIZE-1:0]         flit_out,
   output logic [PORT_CNT-1:0]                   flit_valid_out,
   output logic [PORT_CNT*VC_W-1:0]              vc_out,
   output logic                                  credit_err
);

   localparam int CW = $clog2(CREDIT_DEPTH + 1);
   localparam int SLOTS = PORT_CNT * VC_NUM;

   logic [CW-1:0]        credit_cnt [SLOTS];
   logic [CW-1:0]        credit_nxt [SLOTS];
   logic                 err_set;

   logic [VC_W-1:0]      vc_ptr     [PORT_CNT];
   logic [VC_W-1:0]      vc_ptr_nxt [PORT_CNT];
   logic [PORT_W-1:0]    in_ptr     [PORT_CNT];
   logic [PORT_W-1:0]    in_ptr_nxt [PORT_CNT];

   logic [SLOTS-1:0]     elig;

   logic [PORT_CNT-1:0]  s1_valid;
   logic [VC_W-1:0]      s1_vc   [PORT_CNT];
   logic [PORT_W-1:0]    s1_port [PORT_CNT];

   logic [PORT_CNT-1:0]  o_valid;
   logic [PORT_W-1:0]    o_src  [PORT_CNT];
   logic [VC_W-1:0]      o_vc   [PORT_CNT];
   logic [FLIT_SIZE-1:0] o_flit [PORT_CNT];

   // Eligibility: a head may compete only if it targets a real output port
   // and the downstream buffer for that (output, VC) has at least one slot.
   // Out-of-range port numbers simply never match any output index.
   always_comb begin : eligibility
      int idx;
      idx  = 0;
      elig = '0;
      for (int i = 0; i < PORT_CNT; i++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            idx = i * VC_NUM + v;
            for (int o = 0; o < PORT_CNT; o++) begin
               if (req[idx] &&
                   (int'(req_port[idx*PORT_W +: PORT_W]) == o) &&
                   (credit_cnt[o*VC_NUM+v] != '0)) begin
                  elig[idx] = 1'b1;
               end
            end
         end
      end
   end

   // VC stage: each input scans its VCs starting at vc_ptr and keeps the
   // first eligible one it meets.
   always_comb begin : vc_stage
      int v;
      v        = 0;
      s1_valid = '0;
      for (int i = 0; i < PORT_CNT; i++) begin
         s1_vc[i]   = '0;
         s1_port[i] = '0;
      end
      for (int i = 0; i < PORT_CNT; i++) begin
         for (int k = 0; k < VC_NUM; k++) begin
            v = int'(vc_ptr[i]) + k;
            if (v >= VC_NUM) v = v - VC_NUM;
            if (!s1_valid[i] && elig[i*VC_NUM+v]) begin
               s1_valid[i] = 1'b1;
               s1_vc[i]    = VC_W'(v);
               s1_port[i]  = req_port[(i*VC_NUM+v)*PORT_W +: PORT_W];
            end
         end
      end
   end

   // Input stage: each output scans inputs starting at in_ptr and takes the
   // first whose VC-stage winner targets it. The final grant, the steering
   // of the winning flit and the pointer advances all derive from here, so
   // a VC winner that loses this stage leaves its vc_ptr untouched.
   always_comb begin : input_stage
      int i;
      int nxt;
      i       = 0;
      nxt     = 0;
      o_valid = '0;
      grant   = '0;
      for (int o = 0; o < PORT_CNT; o++) begin
         o_src[o]      = '0;
         o_vc[o]       = '0;
         o_flit[o]     = '0;
         in_ptr_nxt[o] = in_ptr[o];
         vc_ptr_nxt[o] = vc_ptr[o];
      end
      for (int o = 0; o < PORT_CNT; o++) begin
         for (int k = 0; k < PORT_CNT; k++) begin
            i = int'(in_ptr[o]) + k;
            if (i >= PORT_CNT) i = i - PORT_CNT;
            if (!o_valid[o] && s1_valid[i] && (int'(s1_port[i]) == o)) begin
               o_valid[o] = 1'b1;
               o_src[o]   = PORT_W'(i);
               o_vc[o]    = s1_vc[i];
            end
         end
      end
      for (int o = 0; o < PORT_CNT; o++) begin
         if (o_valid[o]) begin
            o_flit[o] = flit_in[(int'(o_src[o])*VC_NUM + int'(o_vc[o]))*FLIT_SIZE +: FLIT_SIZE];
            if (rst_n) grant[int'(o_src[o])*VC_NUM + int'(o_vc[o])] = 1'b1;
            nxt = int'(o_src[o]) + 1;
            if (nxt >= PORT_CNT) nxt = 0;
            in_ptr_nxt[o] = PORT_W'(nxt);
            nxt = int'(o_vc[o]) + 1;
            if (nxt >= VC_NUM) nxt = 0;
            vc_ptr_nxt[int'(o_src[o])] = VC_W'(nxt);
         end
      end
   end

   // Credit bookkeeping per (output, VC): a grant consumes a slot, a credit
   // return frees one, both together cancel. Overflow saturates and
   // underflow holds at zero; both raise the error flag.
   always_comb begin : credit_update
      int  idx;
      logic dec;
      logic inc;
      idx        = 0;
      dec        = 1'b0;
      inc        = 1'b0;
      credit_nxt = credit_cnt;
      err_set    = 1'b0;
      for (int o = 0; o < PORT_CNT; o++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            idx = o * VC_NUM + v;
            dec = o_valid[o] && (int'(o_vc[o]) == v);
            inc = credit_in[idx];
            if (inc && !dec) begin
               if (credit_cnt[idx] == CW'(CREDIT_DEPTH)) err_set = 1'b1;
               else credit_nxt[idx] = credit_cnt[idx] + CW'(1);
            end else if (dec && !inc) begin
               if (credit_cnt[idx] == '0) err_set = 1'b1;
               else credit_nxt[idx] = credit_cnt[idx] - CW'(1);
            end
         end
      end
   end

   // State and output registers. Reset restores full credit, rewinds both
   // pointer sets and drops anything in flight on the output links. Outputs
   // without a grant clear their valid but keep the last flit and VC tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SLOTS; k++) credit_cnt[k] <= CW'(CREDIT_DEPTH);
         for (int k = 0; k < PORT_CNT; k++) begin
            vc_ptr[k] <= '0;
            in_ptr[k] <= '0;
         end
         flit_out       <= '0;
         flit_valid_out <= '0;
         vc_out         <= '0;
         credit_err     <= 1'b0;
      end else begin
         credit_cnt <= credit_nxt;
         vc_ptr     <= vc_ptr_nxt;
         in_ptr     <= in_ptr_nxt;
         credit_err <= credit_err | err_set;
         for (int o = 0; o < PORT_CNT; o++) begin
            flit_valid_out[o] <= o_valid[o];
            if (o_valid[o]) begin
               flit_out[o*FLIT_SIZE +: FLIT_SIZE] <= o_flit[o];
               vc_out[o*VC_W +: VC_W]             <= o_vc[o];
            end
         end
      end
   end

endmodule

// File: tb/tb_vc_switch_allocator_rr.sv
// ---------------------------------------------------------------------------
// tb_vc_switch_allocator_rr
//
// Directed bench for vc_switch_allocator_rr with the default parameters.
// Grants are compared in the cycle they are requested; each expected grant
// also queues the registered output it must produce, and an independent
// monitor pops and compares that record whenever the DUT shows a valid flit.
// ---------------------------------------------------------------------------
module tb_vc_switch_allocator_rr;

   localparam int PC = 5;
   localparam int VN = 4;
   localparam int FS = 32;
   localparam int PW = 3;
   localparam int VW = 2;
   localparam int SL = PC * VN;

   logic               clk;
   logic               rst_n;
   logic [SL-1:0]      req;
   logic [SL*PW-1:0]   req_port;
   logic [SL*FS-1:0]   flit_in;
   logic [SL-1:0]      credit_in;
   logic [SL-1:0]      grant;
   logic [PC*FS-1:0]   flit_out;
   logic [PC-1:0]      flit_valid_out;
   logic [PC*VW-1:0]   vc_out;
   logic               credit_err;

   logic [PW-1:0]      port_a [SL];
   logic [FS-1:0]      flit_a [SL];

   typedef struct packed {
      logic [PC-1:0]    mask;
      logic [PC*FS-1:0] flits;
      logic [PC*VW-1:0] vcs;
   } exp_rec_t;

   exp_rec_t exp_q [$];
   exp_rec_t mon_rec;

   int checks_total;
   int checks_passed;

   vc_switch_allocator_rr #(
      .PORT_CNT(PC), .VC_NUM(VN), .FLIT_SIZE(FS), .CREDIT_DEPTH(4), .PORT_W(PW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_port(req_port),
      .flit_in(flit_in), .credit_in(credit_in), .grant(grant),
      .flit_out(flit_out), .flit_valid_out(flit_valid_out),
      .vc_out(vc_out), .credit_err(credit_err)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flatten the per-slot tables onto the DUT input vectors.
   always_comb begin
      req_port = '0;
      flit_in  = '0;
      for (int k = 0; k < SL; k++) begin
         req_port[k*PW +: PW] = port_a[k];
         flit_in[k*FS +: FS]  = flit_a[k];
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks_total++;
      if (actual === expected) checks_passed++;
      else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
   endtask

   task automatic setSlot(input int idx, input logic [PW-1:0] p, input logic [FS-1:0] f);
      port_a[idx] = p;
      flit_a[idx] = f;
   endtask

   // Drive one cycle (caller is already at a falling edge), compare the
   // combinational grant and queue the output record it implies.
   task automatic applyStimulus(input logic [SL-1:0] r, input logic [SL-1:0] cin,
                                input logic [SL-1:0] exp_g, input string name);
      exp_rec_t rec;
      int o;
      req       = r;
      credit_in = cin;
      #1;
      checkOutput(name, 64'(grant), 64'(exp_g));
      rec = '0;
      for (int k = 0; k < SL; k++) begin
         if (exp_g[k]) begin
            o = int'(port_a[k]);
            rec.mask[o]            = 1'b1;
            rec.flits[o*FS +: FS]  = flit_a[k];
            rec.vcs[o*VW +: VW]    = VW'(k % VN);
         end
      end
      if (exp_g != '0) exp_q.push_back(rec);
   endtask

   task automatic doReset(input string name);
      @(negedge clk);
      rst_n     = 1'b0;
      req       = '0;
      credit_in = '0;
      #1;
      checkOutput({name, "_grant"}, 64'(grant), 64'(0));
      checkOutput({name, "_valid"}, 64'(flit_valid_out), 64'(0));
      checkOutput({name, "_flit"}, 64'(flit_out != '0), 64'(0));
      checkOutput({name, "_vc"}, 64'(vc_out), 64'(0));
      checkOutput({name, "_err"}, 64'(credit_err), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: whenever an output link is valid, pop the oldest queued
   // record and compare valid mask, flits and VC tags.
   always @(negedge clk) begin
      if (rst_n && flit_valid_out != '0) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_output", 64'(flit_valid_out), 64'(0));
         end else begin
            mon_rec = exp_q.pop_front();
            checkOutput("out_valid_mask", 64'(flit_valid_out), 64'(mon_rec.mask));
            for (int o = 0; o < PC; o++) begin
               if (mon_rec.mask[o]) begin
                  checkOutput($sformatf("out_flit[%0d]", o),
                              64'(flit_out[o*FS +: FS]), 64'(mon_rec.flits[o*FS +: FS]));
                  checkOutput($sformatf("out_vc[%0d]", o),
                              64'(vc_out[o*VW +: VW]), 64'(mon_rec.vcs[o*VW +: VW]));
               end
            end
         end
      end
   end

   initial begin : stimulus
      int win [6];
      checks_total  = 0;
      checks_passed = 0;
      rst_n     = 1'b0;
      req       = '0;
      credit_in = '0;
      for (int k = 0; k < SL; k++) begin
         port_a[k] = '0;
         flit_a[k] = '0;
      end

      doReset("reset_init");

      // Single request: input 0 VC 0 to port 2.
      @(negedge clk);
      setSlot(0, 3'd2, 32'hA5A5_0001);
      applyStimulus(20'h1, '0, 20'h1, "single_grant");
      @(negedge clk);
      applyStimulus('0, '0, '0, "single_idle");

      // Credit exhaustion on (output 3, VC 1) from input 1 VC 1.
      doReset("reset_t2");
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         setSlot(5, 3'd3, 32'h2000_0000 + k);
         applyStimulus(20'(1 << 5), (k == 5) ? 20'(1 << 13) : '0,
                       (k < 4 || k == 6) ? 20'(1 << 5) : '0, "credit_exhaust");
      end
      @(negedge clk);
      applyStimulus('0, '0, '0, "exhaust_idle");

      // Output contention: inputs 0, 1, 4 on VC 0 all want port 1.
      doReset("reset_t3");
      win = '{0, 1, 4, 0, 1, 4};
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         setSlot(0,  3'd1, 32'h3000_0000 | (k << 8) | 0);
         setSlot(4,  3'd1, 32'h3000_0000 | (k << 8) | 1);
         setSlot(16, 3'd1, 32'h3000_0000 | (k << 8) | 4);
         applyStimulus(20'h1_0011, 20'(1 << 4), 20'(1 << (win[k] * VN)), "contention");
      end
      @(negedge clk);
      applyStimulus('0, '0, '0, "contention_idle");
      @(negedge clk);
      checkOutput("contention_err", 64'(credit_err), 64'(0));

      // VC fairness: input 2, all four VCs, port 0.
      doReset("reset_t4");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         for (int v = 0; v < VN; v++) setSlot(8 + v, 3'd0, 32'h4000_0000 | (k << 4) | v);
         applyStimulus(20'h0_0F00, 20'(1 << (k % VN)), 20'(1 << (8 + k % VN)), "vc_fair");
      end
      @(negedge clk);
      applyStimulus('0, '0, '0, "vc_fair_idle");
      @(negedge clk);
      checkOutput("vc_fair_err", 64'(credit_err), 64'(0));

      // Simultaneous grant + credit on (4, 2) at credit 1, then overflow.
      doReset("reset_t5");
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         setSlot(2, 3'd4, 32'h5000_0000 + k);
         applyStimulus(20'(1 << 2), (k == 3) ? 20'(1 << 18) : '0,
                       (k < 5) ? 20'(1 << 2) : '0, "grant_plus_credit");
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         applyStimulus('0, 20'(1 << 18), '0, "refill");
      end
      @(negedge clk);
      checkOutput("err_before_overflow", 64'(credit_err), 64'(0));
      applyStimulus('0, 20'(1 << 18), '0, "overflow_pulse");
      @(negedge clk);
      checkOutput("err_after_overflow", 64'(credit_err), 64'(1));
      applyStimulus('0, '0, '0, "overflow_idle");
      @(negedge clk);
      checkOutput("err_sticky", 64'(credit_err), 64'(1));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         setSlot(2, 3'd4, 32'h5100_0000 + k);
         applyStimulus(20'(1 << 2), '0, (k < 4) ? 20'(1 << 2) : '0, "saturated_credit");
      end
      @(negedge clk);
      applyStimulus('0, '0, '0, "saturated_idle");

      // Reset mid-operation: input 1 VC 0 uses two credits on port 0.
      doReset("reset_t6");
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         setSlot(4, 3'd0, 32'h6000_0000 + k);
         applyStimulus(20'(1 << 4), '0, 20'(1 << 4), "pre_reset");
      end
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_valid", 64'(flit_valid_out), 64'(0));
      checkOutput("midreset_flit", 64'(flit_out != '0), 64'(0));
      checkOutput("midreset_vc", 64'(vc_out), 64'(0));
      checkOutput("midreset_grant", 64'(grant), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      setSlot(4,  3'd0, 32'h6100_0001);
      setSlot(12, 3'd0, 32'h6100_0003);
      applyStimulus(20'h0_1010, '0, 20'(1 << 4), "post_reset_ptr");
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         setSlot(4, 3'd0, 32'h6200_0000 + k);
         applyStimulus(20'(1 << 4), '0, (k < 3) ? 20'(1 << 4) : '0, "post_reset_credit");
      end
      @(negedge clk);
      applyStimulus('0, '0, '0, "final_idle");
      repeat (2) @(negedge clk);
      #1;
      checkOutput("queue_drain", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
